vram_arbiter: RTL and testbench

Shares the single-port 8-bit pixel RAM between the VGA scan-out engine and the CPU. VGA reads have absolute priority and see zero added latency. CPU writes are buffered in a small FIFO and drained into the RAM on cycles where the scan-out engine is not reading. The block also derives a vertical-blank flag from the scan-out read strobe, so software can schedule frame-synchronous updates. It sits between the VGA timing controller, the CPU bus and the pixel RAM, all in the vga_clk domain.

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_wfifo.sv | 37 +++
 rtl/vram_arbiter.sv | 89 ++++++++
 tb/tb_vram_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared pixel, address and arbiter-state types for the VRAM arbiter.
package vram_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    typedef logic [7:0] pix_t;
    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
    } vaddr_t;
    typedef struct packed {
        vaddr_t addr;
        pix_t   data;
    } wreq_t;
    typedef enum logic [1:0] {VIDEO = 2'd0, HBLANK = 2'd1, VBLANK = 2'd2} arb_state_t;
endpackage

// File: rtl/vram_wfifo.sv
// vram_wfifo: DEPTH-entry synchronous FIFO with wrap-bit pointers buffering CPU pixel writes.
module vram_wfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 27
) (
    input  logic         vga_clk,
    input  logic         clrn,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    always_comb begin
        wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d = (pop_i && !empty_o) ? rd_q + (AW+1)'(1) : rd_q;
    end
    always_ff @(posedge vga_clk or negedge clrn)
        if (!clrn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    always_ff @(posedge vga_clk)
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the pixel RAM between VGA scan-out (priority) and buffered CPU writes; flags vblank.
// Optional VRAM_ARB_STATS_EN adds stall_cnt_o / drop_cnt_o statistics counters.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [9:0] VBLANK_TH = 10'd200
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic        vga_rdn_i,
    input  logic [8:0]  vga_row_i,
    input  logic [9:0]  vga_col_i,
    output logic [7:0]  vga_data_o,
    input  logic        cpu_req_i,
    input  logic [18:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_ready_o,
    output logic        in_vblank_o,
`ifdef VRAM_ARB_STATS_EN
    output logic [15:0] stall_cnt_o,
    output logic [7:0]  drop_cnt_o,
`endif
    output logic [18:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [7:0]  ram_rdata_i
);
    wreq_t      head, wreq;
    logic       full, empty, in_range, push;
    logic [9:0] gap_q, gap_d;
    arb_state_t state_q, state_d;

    assign wreq        = '{addr: vaddr_t'(cpu_addr_i), data: pix_t'(cpu_wdata_i)};
    assign in_range    = (wreq.addr.row < 9'(V_ACTIVE)) && (wreq.addr.col < 10'(H_ACTIVE));
    assign cpu_ready_o = !full;
    assign push        = cpu_req_i && !full && in_range;

    vram_wfifo #(.DEPTH(DEPTH), .W($bits(wreq_t))) u_wfifo (
        .vga_clk (vga_clk),
        .clrn    (clrn),
        .push_i  (push),
        .pop_i   (ram_we_o),
        .wdata_i (wreq),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // vga_rdn is registered upstream, so this mux only switches on clock edges
    assign ram_we_o    = vga_rdn_i && !empty;
    assign ram_addr_o  = vga_rdn_i ? head.addr : {vga_row_i, vga_col_i};
    assign ram_wdata_o = head.data;
    assign vga_data_o  = ram_rdata_i;
    assign in_vblank_o = state_q == VBLANK;

    always_comb begin
        gap_d   = !vga_rdn_i ? '0 : (gap_q >= VBLANK_TH ? gap_q : gap_q + 10'd1);
        state_d = !vga_rdn_i ? VIDEO : (gap_q >= VBLANK_TH ? VBLANK : HBLANK);
    end

    always_ff @(posedge vga_clk or negedge clrn)
        if (!clrn) begin
            gap_q   <= '0;
            state_q <= VIDEO;
        end else begin
            gap_q   <= gap_d;
            state_q <= state_d;
        end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [7:0]  drop_q, drop_d;
    always_comb begin
        stall_d = (cpu_req_i && !cpu_ready_o && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        drop_d  = (cpu_req_i && cpu_ready_o && !in_range) ? drop_q + 8'd1 : drop_q;
    end
    always_ff @(posedge vga_clk or negedge clrn)
        if (!clrn) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            stall_q <= stall_d;
            drop_q  <= drop_d;
        end
    assign stall_cnt_o = stall_q;
    assign drop_cnt_o  = drop_q;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed plus randomized checks of vram_arbiter against a queue-based reference model.
module tb_vram_arbiter;
    localparam int DEPTH = 4;
    localparam int TH    = 200;

    logic        vga_clk = 1'b0;
    logic        clrn    = 1'b0;
    logic        vga_rdn = 1'b1;
    logic [8:0]  vga_row = '0;
    logic [9:0]  vga_col = '0;
    logic        cpu_req = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  vga_data, ram_wdata, ram_rdata;
    logic [18:0] ram_addr;
    logic        cpu_ready, in_vblank, ram_we;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [7:0]  drop_cnt;
`endif

    logic [26:0] q[$];
    int          run = 0;
    int          stall_m = 0;
    int          drop_m = 0;
    int          tests = 0;
    int          fails = 0;

    vram_arbiter #(.DEPTH(DEPTH), .VBLANK_TH(10'(TH))) dut (
        .vga_clk     (vga_clk),
        .clrn        (clrn),
        .vga_rdn_i   (vga_rdn),
        .vga_row_i   (vga_row),
        .vga_col_i   (vga_col),
        .vga_data_o  (vga_data),
        .cpu_req_i   (cpu_req),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_ready_o (cpu_ready),
        .in_vblank_o (in_vblank),
`ifdef VRAM_ARB_STATS_EN
        .stall_cnt_o (stall_cnt),
        .drop_cnt_o  (drop_cnt),
`endif
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    always #20 vga_clk = ~vga_clk;

    // RAM model: contents are a fixed scramble of the address
    function automatic logic [7:0] rf(input logic [18:0] a);
        return a[7:0] ^ a[18:11] ^ 8'h5A;
    endfunction
    assign ram_rdata = rf(ram_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] addr(input int row, input int col);
        return {9'(row), 10'(col)};
    endfunction

    task automatic cyc(input logic rdn, input logic req, input logic [18:0] a, input logic [7:0] d);
        logic rdy, we, inr;
        vga_rdn = rdn; cpu_req = req; cpu_addr = a; cpu_wdata = d;
        vga_row = 9'($urandom); vga_col = 10'($urandom);
        @(negedge vga_clk);
        rdy = q.size() < DEPTH;
        we  = rdn && q.size() != 0;
        chk("cpu_ready", 32'(cpu_ready), 32'(rdy));
        chk("ram_we", 32'(ram_we), 32'(we));
        if (we) begin
            chk("wr_addr", 32'(ram_addr), 32'(q[0][26:8]));
            chk("wr_data", 32'(ram_wdata), 32'(q[0][7:0]));
        end
        if (!rdn) begin
            chk("rd_addr", 32'(ram_addr), 32'({vga_row, vga_col}));
            chk("vga_data", 32'(vga_data), 32'(rf({vga_row, vga_col})));
        end
        chk("in_vblank", 32'(in_vblank), 32'(run > TH));
`ifdef VRAM_ARB_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        chk("drop_cnt", 32'(drop_cnt), 32'(drop_m % 256));
`endif
        inr = int'(a[18:10]) < 480 && int'(a[9:0]) < 640;
        if (we) void'(q.pop_front());
        if (req && rdy && inr) q.push_back({a, d});
        if (req && !rdy && stall_m < 65535) stall_m++;
        if (req && rdy && !inr) drop_m++;
        run = rdn ? run + 1 : 0;
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        logic rdn;
        int s0;
        // reset with the scan-out mid-frame
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_vblank", 32'(in_vblank), 32'd0);
        clrn = 1'b1;
        repeat (5) cyc(1'b1, 1'b0, '0, '0);

        // four writes during active video fill the FIFO, then drain in order
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, addr(i * 3, 100 + i), 8'(8'h10 + i));
        chk("full_ready", 32'(cpu_ready), 32'd0);
        cyc(1'b0, 1'b0, '0, '0);
        repeat (5) cyc(1'b1, 1'b0, '0, '0);
        chk("drained", 32'(q.size()), 32'd0);

        // out-of-range write is accepted and dropped
        cyc(1'b1, 1'b1, addr(10, 700), 8'hAA);
        chk("oor_ready", 32'(cpu_ready), 32'd1);
        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, addr(480, 5), 8'hBB);
        cyc(1'b1, 1'b0, '0, '0);
`ifdef VRAM_ARB_STATS_EN
        chk("drop_two", 32'(drop_cnt), 32'd2);
`endif

        // horizontal blank does not raise vblank, a long gap does
        cyc(1'b0, 1'b0, '0, '0);
        repeat (160) cyc(1'b1, 1'b0, '0, '0);
        chk("hblank_vb", 32'(in_vblank), 32'd0);
        cyc(1'b0, 1'b0, '0, '0);
        repeat (TH) cyc(1'b1, 1'b0, '0, '0);
        chk("vb_edge_lo", 32'(in_vblank), 32'd0);
        cyc(1'b1, 1'b0, '0, '0);
        chk("vb_edge_hi", 32'(in_vblank), 32'd1);
        repeat (300) cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0);
        chk("vb_clear", 32'(in_vblank), 32'd0);

        // stall while full during active video
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, addr(200 + i, 600 + i), 8'(8'hC0 + i));
        s0 = stall_m;
        repeat (10) cyc(1'b0, 1'b1, addr(7, 7), 8'h77);
        chk("stall_ten", 32'(stall_m - s0), 32'd10);
`ifdef VRAM_ARB_STATS_EN
        chk("stall_cnt10", 32'(stall_cnt), 32'(s0 + 10));
`endif
        // scan-out resumes with the FIFO non-empty
        repeat (2) cyc(1'b1, 1'b0, '0, '0);
        repeat (3) cyc(1'b0, 1'b0, '0, '0);
        repeat (3) cyc(1'b1, 1'b0, '0, '0);

        // randomized traffic
        rdn = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [18:0] a;
            if ($urandom_range(0, 7) == 0) rdn = ~rdn;
            a = ($urandom_range(0, 3) == 0) ? 19'($urandom)
                                            : addr($urandom_range(0, 479), $urandom_range(0, 639));
            cyc(rdn, 1'($urandom), a, 8'($urandom));
        end

        // reset mid-drain
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, addr(50 + i, 60), 8'(8'hE0 + i));
        vga_rdn = 1'b1; cpu_req = 1'b0;
        @(negedge vga_clk);
        chk("drain_we", 32'(ram_we), 32'd1);
        #5 clrn = 1'b0;
        #1;
        chk("mid_rst_we", 32'(ram_we), 32'd0);
        chk("mid_rst_ready", 32'(cpu_ready), 32'd1);
        chk("mid_rst_vb", 32'(in_vblank), 32'd0);
        @(posedge vga_clk);
        #1;
        clrn = 1'b1;
        q.delete(); run = 0; stall_m = 0; drop_m = 0;
        repeat (5) cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, addr(1, 2), 8'h33);
        repeat (2) cyc(1'b1, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
